// File: rtl/tcp_tx_pipe_ctrl_pkg.sv
// Shared constants for the TCP slow-path TX control FSM: channel counts and the
// bit positions used inside the read-request and output handshake vectors.
package tcp_tx_pipe_ctrl_pkg;

    localparam int unsigned NumRdChans  = 4;
    localparam int unsigned NumOutChans = 3;

    localparam int unsigned RdTailPtr     = 0;
    localparam int unsigned RdCurrTxState = 1;
    localparam int unsigned RdRxState     = 2;
    localparam int unsigned RdTuple       = 3;

    localparam int unsigned OutNextTxState = 0;
    localparam int unsigned OutSchedUpdate = 1;
    localparam int unsigned OutTxPkt       = 2;

endpackage

// File: rtl/tcp_tx_hs_join.sv
// N-way valid/ready fan-out: each lane's val stays up until its own transfer
// completes, and all_done fires in the cycle the last outstanding lane completes.
module tcp_tx_hs_join #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] skip,
    output logic [N-1:0] val,
    input  logic [N-1:0] rdy,
    output logic         all_done
);

    logic [N-1:0] done_q;
    logic [N-1:0] done_d;
    logic [N-1:0] done_eff;
    logic [N-1:0] accept;

    always_comb begin
        done_eff = done_q | skip;
        val      = en ? ~done_eff : '0;
        accept   = val & rdy;
        all_done = en & (&(done_eff | accept));
        done_d   = done_q;
        // Mask clears on completion so the next use starts fresh.
        if (all_done) begin
            done_d = '0;
        end else if (en) begin
            done_d = done_q | accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/tcp_tx_pipe_ctrl.sv
// Control FSM for the TCP slow-path TX datapath: one request in flight, four state/tuple
// reads joined before capture, then write-back, scheduler update and optional packet out.
module tcp_tx_pipe_ctrl
    import tcp_tx_pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,

    input  logic sched_tx_req_val,
    output logic sched_tx_req_rdy,

    output logic tx_pipe_tx_tail_ptr_rd_req_val,
    input  logic tx_pipe_tx_tail_ptr_rd_req_rdy,
    input  logic tx_tail_ptr_tx_pipe_rd_resp_val,
    output logic tx_tail_ptr_tx_pipe_rd_resp_rdy,

    output logic proto_calc_curr_tx_state_rd_req_val,
    input  logic proto_calc_curr_tx_state_rd_req_rdy,
    input  logic curr_tx_state_proto_calc_rd_resp_val,
    output logic curr_tx_state_proto_calc_rd_resp_rdy,

    output logic proto_calc_rx_state_rd_req_val,
    input  logic proto_calc_rx_state_rd_req_rdy,
    input  logic rx_state_proto_calc_rd_resp_val,
    output logic rx_state_proto_calc_rd_resp_rdy,

    output logic proto_calc_tuple_rd_req_val,
    input  logic proto_calc_tuple_rd_req_rdy,
    input  logic tuple_proto_calc_rd_resp_val,
    output logic tuple_proto_calc_rd_resp_rdy,

    output logic proto_calc_next_tx_state_wr_req_val,
    input  logic proto_calc_next_tx_state_wr_req_rdy,

    output logic proto_calc_tx_pkt_val,
    input  logic proto_calc_tx_pkt_rdy,

    output logic tx_sched_update_cmd_val,
    input  logic tx_sched_update_cmd_rdy,

    output logic ctrl_datap_store_flowid,
    output logic ctrl_datap_store_state,
    output logic ctrl_datap_store_tuple,
    output logic ctrl_datap_store_calc,
    input  logic datap_ctrl_produce_pkt
);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdResp,
        StCalc,
        StOutput
    } tcp_tx_ctrl_state_e;

    tcp_tx_ctrl_state_e state_q, state_d;
    logic out_first_q;
    logic pkt_needed_q, pkt_needed_d;
    logic pkt_needed;

    logic [NumRdChans-1:0]  rd_req_val, rd_req_rdy, rd_resp_val;
    logic [NumOutChans-1:0] out_val, out_rdy, out_skip;
    logic rd_all_done, out_all_done;
    logic all_resp_val, resp_take;

    assign rd_req_rdy[RdTailPtr]     = tx_pipe_tx_tail_ptr_rd_req_rdy;
    assign rd_req_rdy[RdCurrTxState] = proto_calc_curr_tx_state_rd_req_rdy;
    assign rd_req_rdy[RdRxState]     = proto_calc_rx_state_rd_req_rdy;
    assign rd_req_rdy[RdTuple]       = proto_calc_tuple_rd_req_rdy;

    assign rd_resp_val[RdTailPtr]     = tx_tail_ptr_tx_pipe_rd_resp_val;
    assign rd_resp_val[RdCurrTxState] = curr_tx_state_proto_calc_rd_resp_val;
    assign rd_resp_val[RdRxState]     = rx_state_proto_calc_rd_resp_val;
    assign rd_resp_val[RdTuple]       = tuple_proto_calc_rd_resp_val;

    assign out_rdy[OutNextTxState] = proto_calc_next_tx_state_wr_req_rdy;
    assign out_rdy[OutSchedUpdate] = tx_sched_update_cmd_rdy;
    assign out_rdy[OutTxPkt]       = proto_calc_tx_pkt_rdy;

    assign tx_pipe_tx_tail_ptr_rd_req_val      = rd_req_val[RdTailPtr];
    assign proto_calc_curr_tx_state_rd_req_val = rd_req_val[RdCurrTxState];
    assign proto_calc_rx_state_rd_req_val      = rd_req_val[RdRxState];
    assign proto_calc_tuple_rd_req_val         = rd_req_val[RdTuple];

    assign proto_calc_next_tx_state_wr_req_val = out_val[OutNextTxState];
    assign tx_sched_update_cmd_val             = out_val[OutSchedUpdate];
    assign proto_calc_tx_pkt_val               = out_val[OutTxPkt];

    assign tx_tail_ptr_tx_pipe_rd_resp_rdy     = resp_take;
    assign curr_tx_state_proto_calc_rd_resp_rdy = resp_take;
    assign rx_state_proto_calc_rd_resp_rdy     = resp_take;
    assign tuple_proto_calc_rd_resp_rdy        = resp_take;

    assign all_resp_val = &rd_resp_val;
    // produce_pkt is only valid from the first OUTPUT cycle; registered thereafter.
    assign pkt_needed   = out_first_q ? datap_ctrl_produce_pkt : pkt_needed_q;

    tcp_tx_hs_join #(
        .N (NumRdChans)
    ) u_rd_join (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == StRdReq),
        .skip     ('0),
        .val      (rd_req_val),
        .rdy      (rd_req_rdy),
        .all_done (rd_all_done)
    );

    tcp_tx_hs_join #(
        .N (NumOutChans)
    ) u_out_join (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == StOutput),
        .skip     (out_skip),
        .val      (out_val),
        .rdy      (out_rdy),
        .all_done (out_all_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            out_first_q  <= 1'b0;
            pkt_needed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_first_q  <= (state_q == StCalc);
            pkt_needed_q <= pkt_needed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pkt_needed_d = pkt_needed_q;
        unique case (state_q)
            StIdle: begin
                pkt_needed_d = 1'b0;
                if (sched_tx_req_val) state_d = StRdReq;
            end
            StRdReq: begin
                if (rd_all_done) state_d = StRdResp;
            end
            StRdResp: begin
                if (all_resp_val) state_d = StCalc;
            end
            StCalc: begin
                state_d = StOutput;
            end
            StOutput: begin
                if (out_first_q) pkt_needed_d = datap_ctrl_produce_pkt;
                if (out_all_done) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        sched_tx_req_rdy        = (state_q == StIdle) & ~rst;
        ctrl_datap_store_flowid = (state_q == StIdle) & ~rst & sched_tx_req_val;
        resp_take               = (state_q == StRdResp) & all_resp_val;
        ctrl_datap_store_state  = resp_take;
        ctrl_datap_store_tuple  = resp_take;
        ctrl_datap_store_calc   = (state_q == StCalc);
        out_skip                = '0;
        out_skip[OutTxPkt]      = ~pkt_needed;
    end

endmodule

// File: tb/tb_tcp_tx_pipe_ctrl.sv
// Bench for tcp_tx_pipe_ctrl: memory/consumer models with scheduled stalls and latencies,
// checked against a transaction-timeline model derived from the handshake rules.
module tb_tcp_tx_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sched_val, sched_rdy;
    logic [3:0] req_val, req_rdy, resp_val, resp_rdy;
    logic [2:0] out_val, out_rdy;
    logic       st_flowid, st_state, st_tuple, st_calc, produce;

    tcp_tx_pipe_ctrl dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .sched_tx_req_val                    (sched_val),
        .sched_tx_req_rdy                    (sched_rdy),
        .tx_pipe_tx_tail_ptr_rd_req_val      (req_val[0]),
        .tx_pipe_tx_tail_ptr_rd_req_rdy      (req_rdy[0]),
        .tx_tail_ptr_tx_pipe_rd_resp_val     (resp_val[0]),
        .tx_tail_ptr_tx_pipe_rd_resp_rdy     (resp_rdy[0]),
        .proto_calc_curr_tx_state_rd_req_val (req_val[1]),
        .proto_calc_curr_tx_state_rd_req_rdy (req_rdy[1]),
        .curr_tx_state_proto_calc_rd_resp_val(resp_val[1]),
        .curr_tx_state_proto_calc_rd_resp_rdy(resp_rdy[1]),
        .proto_calc_rx_state_rd_req_val      (req_val[2]),
        .proto_calc_rx_state_rd_req_rdy      (req_rdy[2]),
        .rx_state_proto_calc_rd_resp_val     (resp_val[2]),
        .rx_state_proto_calc_rd_resp_rdy     (resp_rdy[2]),
        .proto_calc_tuple_rd_req_val         (req_val[3]),
        .proto_calc_tuple_rd_req_rdy         (req_rdy[3]),
        .tuple_proto_calc_rd_resp_val        (resp_val[3]),
        .tuple_proto_calc_rd_resp_rdy        (resp_rdy[3]),
        .proto_calc_next_tx_state_wr_req_val (out_val[0]),
        .proto_calc_next_tx_state_wr_req_rdy (out_rdy[0]),
        .proto_calc_tx_pkt_val               (out_val[2]),
        .proto_calc_tx_pkt_rdy               (out_rdy[2]),
        .tx_sched_update_cmd_val             (out_val[1]),
        .tx_sched_update_cmd_rdy             (out_rdy[1]),
        .ctrl_datap_store_flowid             (st_flowid),
        .ctrl_datap_store_state              (st_state),
        .ctrl_datap_store_tuple              (st_tuple),
        .ctrl_datap_store_calc               (st_calc),
        .datap_ctrl_produce_pkt              (produce)
    );

    int total = 0;
    int bad   = 0;

    // Scenario knobs: request stall cycles, response latency, output stall cycles.
    int low[4];
    int lat[4];
    int olow[3];
    bit need_pkt;

    // obs/exp layout: [0:15] event first cycle, [16:31] event count,
    // [32:38] val-high cycles per lane, [39:41] rule violations.
    // Events: 0 flowid, 1 state, 2 tuple, 3 calc, 4-7 req acc, 8-11 resp acc,
    // 12 write, 13 update, 14 pkt, 15 sched_rdy back high.
    int obs[42];
    int exp_v[42];
    bit timed_out;

    function automatic void note(int k, int c);
        if (obs[16+k] == 0) obs[k] = c;
        obs[16+k]++;
    endfunction

    function automatic void build_model();
        int rd_end, arr, rsp, o, last;
        rd_end = 0;
        arr    = 0;
        for (int i = 0; i < 4; i++) begin
            exp_v[4+i]  = 1 + low[i];
            exp_v[32+i] = low[i] + 1;
            if (1 + low[i] > rd_end) rd_end = 1 + low[i];
            if (1 + low[i] + lat[i] > arr) arr = 1 + low[i] + lat[i];
        end
        rsp = (rd_end + 1 > arr) ? rd_end + 1 : arr;
        exp_v[0] = 0;
        exp_v[1] = rsp;
        exp_v[2] = rsp;
        for (int i = 0; i < 4; i++) exp_v[8+i] = rsp;
        exp_v[3] = rsp + 1;
        o = rsp + 2;
        exp_v[12] = o + olow[0];
        exp_v[13] = o + olow[1];
        exp_v[14] = need_pkt ? o + olow[2] : -1;
        last = (olow[0] > olow[1]) ? olow[0] : olow[1];
        if (need_pkt && olow[2] > last) last = olow[2];
        exp_v[15] = o + last + 1;
        for (int k = 0; k < 16; k++) exp_v[16+k] = 1;
        exp_v[30] = need_pkt ? 1 : 0;
        exp_v[36] = olow[0] + 1;
        exp_v[37] = olow[1] + 1;
        exp_v[38] = need_pkt ? olow[2] + 1 : 0;
        for (int k = 39; k < 42; k++) exp_v[k] = 0;
    endfunction

    // Drives one transaction from cycle 0 (entered #1 after a posedge) and records what it sees.
    task automatic run_txn(input bit stop_in_out, output bit stopped);
        int seen[7];
        bit pend[4];
        int rdy_at[4];
        bit accepted, fin;
        logic [6:0] vals, rdys, pv, pa;
        logic [3:0] strb, pstrb;
        for (int k = 0; k < 16; k++) begin
            obs[k] = -1;
            obs[16+k] = 0;
        end
        for (int k = 32; k < 42; k++) obs[k] = 0;
        for (int k = 0; k < 7; k++) seen[k] = 0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0;
            rdy_at[i] = 0;
        end
        pv = '0;
        pa = '0;
        pstrb = '0;
        accepted = 1'b0;
        fin = 1'b0;
        stopped = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            sched_val = !accepted;
            for (int i = 0; i < 4; i++) begin
                req_rdy[i]  = (seen[i] >= low[i]);
                resp_val[i] = pend[i] && (c >= rdy_at[i]);
            end
            for (int j = 0; j < 3; j++) out_rdy[j] = (seen[4+j] >= olow[j]);
            produce = need_pkt;
            @(negedge clk);
            if (stop_in_out && out_val[0]) begin
                stopped = 1'b1;
                return;
            end
            if (accepted && sched_rdy) begin
                note(15, c);
                fin = 1'b1;
            end
            if (sched_val && sched_rdy) accepted = 1'b1;
            strb = {st_calc, st_tuple, st_state, st_flowid};
            for (int k = 0; k < 4; k++) if (strb[k]) note(k, c);
            if (st_calc && st_state) obs[41]++;
            if ((strb & pstrb) != 0) obs[41]++;
            pstrb = strb;
            if (resp_rdy != 4'h0 && (resp_rdy != 4'hf || resp_val != 4'hf)) obs[39]++;
            vals = {out_val, req_val};
            rdys = {out_rdy, req_rdy};
            for (int k = 0; k < 7; k++) begin
                if (vals[k]) begin
                    seen[k]++;
                    obs[32+k]++;
                end
                if (pv[k] && !pa[k] && !vals[k]) obs[40]++;
                if (vals[k] && rdys[k]) note((k < 4) ? 4 + k : 8 + k, c);
            end
            pv = vals;
            pa = vals & rdys;
            for (int i = 0; i < 4; i++) begin
                if (req_val[i] && req_rdy[i]) begin
                    pend[i] = 1'b1;
                    rdy_at[i] = c + lat[i];
                end
                if (resp_val[i] && resp_rdy[i]) begin
                    note(8 + i, c);
                    pend[i] = 1'b0;
                end
            end
            @(posedge clk);
            #1;
        end
        timed_out = !fin;
        sched_val = 1'b0;
        resp_val  = '0;
    endtask

    task automatic set_defaults();
        for (int i = 0; i < 4; i++) begin
            low[i] = 0;
            lat[i] = 1;
        end
        for (int j = 0; j < 3; j++) olow[j] = 0;
        need_pkt = 1'b1;
    endtask

    task automatic test_reset();
        sched_val = 1'b0;
        req_rdy   = '0;
        resp_val  = '0;
        out_rdy   = '0;
        produce   = 1'b0;
        rst       = 1'b1;
        #2;
        total++;
        if ({sched_rdy, req_val, resp_rdy, out_val, st_flowid, st_state, st_tuple, st_calc} !== '0)
        begin
            bad++;
            $display("FAIL reset_hold outputs got=%b exp=0", {sched_rdy, req_val, resp_rdy,
                     out_val, st_flowid, st_state, st_tuple, st_calc});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({sched_rdy, req_val, resp_rdy, out_val, st_calc} !== {1'b1, 11'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_release got=%b exp=%b",
                     {sched_rdy, req_val, resp_rdy, out_val, st_calc}, {1'b1, 12'b0});
        end
    endtask

    task automatic test_single();
        bit s;
        set_defaults();
        build_model();
        run_txn(1'b0, s);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL single timeout got=1 exp=0");
        end
        for (int k = 0; k < 42; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL single item%0d got=%0d exp=%0d", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_req_stall();
        bit s;
        set_defaults();
        low[3] = 3;
        build_model();
        run_txn(1'b0, s);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL req_stall timeout got=1 exp=0");
        end
        for (int k = 0; k < 42; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL req_stall item%0d got=%0d exp=%0d", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_resp_stagger();
        bit s;
        set_defaults();
        lat[0] = 1;
        lat[2] = 4;
        build_model();
        run_txn(1'b0, s);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL resp_stagger timeout got=1 exp=0");
        end
        for (int k = 0; k < 42; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL resp_stagger item%0d got=%0d exp=%0d", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_no_pkt();
        bit s;
        set_defaults();
        need_pkt = 1'b0;
        olow[2]  = 2;
        build_model();
        run_txn(1'b0, s);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL no_pkt timeout got=1 exp=0");
        end
        for (int k = 0; k < 42; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL no_pkt item%0d got=%0d exp=%0d", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_pkt_stall();
        bit s;
        set_defaults();
        olow[2] = 10;
        build_model();
        run_txn(1'b0, s);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL pkt_stall timeout got=1 exp=0");
        end
        for (int k = 0; k < 42; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL pkt_stall item%0d got=%0d exp=%0d", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit s;
        set_defaults();
        olow[0] = 3;
        olow[1] = 3;
        olow[2] = 3;
        build_model();
        run_txn(1'b1, s);
        total++;
        if (s !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid reach_output got=%0d exp=1", s);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({sched_rdy, req_val, resp_rdy, out_val, st_flowid, st_state, st_tuple, st_calc} !== '0)
        begin
            bad++;
            $display("FAIL reset_mid outputs got=%b exp=0", {sched_rdy, req_val, resp_rdy,
                     out_val, st_flowid, st_state, st_tuple, st_calc});
        end
        sched_val = 1'b0;
        resp_val  = '0;
        out_rdy   = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({sched_rdy, req_val, out_val} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_mid idle got=%b exp=10000000", {sched_rdy, req_val, out_val});
        end
        @(posedge clk);
        #1;
        set_defaults();
        build_model();
        run_txn(1'b0, s);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL reset_mid_next timeout got=1 exp=0");
        end
        for (int k = 0; k < 42; k++) begin
            total++;
            if (obs[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL reset_mid_next item%0d got=%0d exp=%0d", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_random();
        bit s;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++) begin
                low[i] = $urandom_range(0, 4);
                lat[i] = $urandom_range(1, 5);
            end
            for (int j = 0; j < 3; j++) olow[j] = $urandom_range(0, 4);
            need_pkt = 1'($urandom_range(0, 1));
            build_model();
            run_txn(1'b0, s);
            total++;
            if (timed_out) begin
                bad++;
                $display("FAIL random%0d timeout got=1 exp=0", n);
            end
            for (int k = 0; k < 42; k++) begin
                total++;
                if (obs[k] !== exp_v[k]) begin
                    bad++;
                    $display("FAIL random%0d item%0d got=%0d exp=%0d", n, k, obs[k], exp_v[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_req_stall();
        test_resp_stagger();
        test_no_pkt();
        test_pkt_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcp_tx_pipe_ctrl.md
# tcp_tx_pipe_ctrl

Control FSM for the TCP slow-path transmit datapath. Accepts one scheduler transmit request at a time and sequences the datapath's capture strobes. Issues the four per-flow state/tuple reads and the next-TX-state write. Emits the assembled packet descriptor and the scheduler flag-update command, all over valid/ready handshakes. Sits between the TX scheduler, the per-flow state memories and the TX packet assembly stage.

## Interface
- No parameters; widths come from `tcp_pkg` / `tcp_misc_pkg`.
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- sched_tx_req_val / sched_tx_req_rdy  in/out  1/1  scheduler request handshake; payload goes straight to the datapath
- tx_pipe_tx_tail_ptr_rd_req_val / _rdy  out/in  1/1  tail-pointer read request
- tx_tail_ptr_tx_pipe_rd_resp_val / _rdy  in/out  1/1  tail-pointer read response
- proto_calc_curr_tx_state_rd_req_val / _rdy, curr_tx_state_proto_calc_rd_resp_val / _rdy  —  1 each  TX-state read request/response
- proto_calc_rx_state_rd_req_val / _rdy, rx_state_proto_calc_rd_resp_val / _rdy  —  1 each  RX-state read request/response
- proto_calc_tuple_rd_req_val / _rdy, tuple_proto_calc_rd_resp_val / _rdy  —  1 each  four-tuple read request/response
- proto_calc_next_tx_state_wr_req_val / _rdy  out/in  1/1  next-TX-state write
- proto_calc_tx_pkt_val / _rdy  out/in  1/1  packet header, payload descriptor and flowid to assembly
- tx_sched_update_cmd_val / _rdy  out/in  1/1  flag-clear command to scheduler
- ctrl_datap_store_flowid / _state / _tuple / _calc  out  1 each  datapath capture strobes
- datap_ctrl_produce_pkt  in  1  datapath: packet is non-empty or carries an rt/ack flag

## Operation
FSM states and transitions:
- **IDLE**
  - sched_tx_req_rdy=1.
  - On val: pulse store_flowid and go to RD_REQ.
- **RD_REQ**
  - Assert the four rd_req_val lines.
  - A 4-bit done mask records each accepted request (val&rdy); a line's val drops once its done bit is set.
  - When all four are done (including the same-cycle acceptance), clear the mask and go to RD_RESP.
- **RD_RESP**
  - All four resp_rdy stay 0 until all four resp_val are 1.
  - In that cycle: all four resp_rdy=1, pulse store_state and store_tuple together, go to CALC.
  - Memories must hold a response until it is accepted.
- **CALC**
  - Pulse store_calc for exactly one cycle, then go to OUTPUT.
  - Sample datap_ctrl_produce_pkt in the cycle after CALC (first OUTPUT cycle) and register it as pkt_needed.
- **OUTPUT**
  - Run three independent handshakes with a 3-bit done mask: state write (always), update command (always), packet (only if pkt_needed; its done bit is preset when pkt_needed=0).
  - When all three are done, go to IDLE.
- Only one request is in flight; no pipelining across requests.
- The flowid and all captured datapath registers stay stable from store_flowid until return to IDLE.

## Timing
- Reset (async assert): state=IDLE, done masks=0, pkt_needed=0.
  - All val, resp_rdy and store strobes are 0.
  - sched_tx_req_rdy=1 after reset deassertion.
- Minimum latency, with every rdy=1 and 1-cycle memories: accept at cycle 0, RD_REQ 1, RD_RESP 2, CALC 3, OUTPUT 4, IDLE 5. A new request is accepted at cycle 5, giving 5 cycles per request.
- Handshake rules:
  - A val, once asserted, stays high until its transfer completes.
  - val never depends combinationally on the same interface's rdy.
  - resp_rdy depends combinationally on resp_val (all-four join).
- Strobes are single-cycle pulses; store_calc is never asserted in the same cycle as store_state.
- Simultaneous events:
  - All requests accepted in the first RD_REQ cycle → leave after 1 cycle.
  - Responses arriving in different cycles → wait; none is consumed early.
  - pkt_needed=0 → no proto_calc_tx_pkt_val pulse, but the write and update still occur.
- Reset mid-operation: abandon the transaction immediately, with no partial outputs after the reset edge. The scheduler re-issues.

## Structure
- `tcp_tx_ctrl_state_e` (IDLE, RD_REQ, RD_RESP, CALC, OUTPUT) is local to the module.
- No new shared-package types are needed.
- One natural sub-module: `tcp_tx_hs_join`, parameterised N-way val/rdy fan-out with a done mask and all_done output. It is used twice, for RD_REQ (N=4) and OUTPUT (N=3).

## Test plan
- Single request, all rdy=1, 1-cycle responses → strobes at cycles 0, 2, 2, 3; pkt/write/update vals at cycle 4; sched_tx_req_rdy high again at cycle 5.
- Request with tuple rd_req_rdy held low 3 cycles → the other three vals drop after 1 cycle; tuple val held for 4 cycles; state advances only after it is accepted.
- Responses staggered: tail ptr at +1, rx state at +4 → no resp_rdy until +4; store_state and store_tuple both pulse at +4.
- produce_pkt=0 → proto_calc_tx_pkt_val never rises; write and update each fire once; return to IDLE.
- proto_calc_tx_pkt_rdy low 10 cycles while the others are ready → write and update complete once; pkt val held for 11 cycles; IDLE after it completes; sched_tx_req_rdy stays low throughout.
- rst asserted in OUTPUT → all vals and strobes low immediately; IDLE with sched_tx_req_rdy=1 after deassertion; the next request proceeds normally.
